jtkunio_pcm_fetch: RTL and testbench

Two-entry byte prefetch buffer between the sound section's ADPCM address generator (17-bit `pcm_addr`, nibble-pair bytes) and the SDRAM ROM port. It hides SDRAM latency by fetching the byte after the one being decoded. The jt5205 decoder then finds its next nibble pair already resident at each sample tick. Core side is a cs/ok read port; ROM side is a standard jtframe cs/ok request.

---
 rtl/jtkunio_snd_pkg.sv | 18 +
 rtl/jtkunio_pcm_slot.sv | 37 +++
 rtl/jtkunio_pcm_fetch.sv | 159 +++++++++++++++
 tb/tb_jtkunio_pcm_fetch.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_snd_pkg.sv
// rtl/jtkunio_snd_pkg.sv - shared types and constants for the sound section PCM fetch path
package jtkunio_snd_pkg;

  localparam int PCM_AW = 17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEMAND = 2'd1,
    ST_PREF   = 2'd2
  } pcm_state_t;

  typedef struct packed {
    logic              valid;
    logic [PCM_AW-1:0] tag;
    logic [7:0]        data;
  } pcm_slot_t;

endpackage

// File: rtl/jtkunio_pcm_slot.sv
// rtl/jtkunio_pcm_slot.sv - one buffered ROM byte: registered {valid, tag, data} with tag compare
module jtkunio_pcm_slot
  import jtkunio_snd_pkg::*;
#(
  parameter int AW = PCM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          inval,
  input  logic [AW-1:0] load_tag,
  input  logic [7:0]    load_data,
  input  logic [AW-1:0] cmp_tag,
  output logic          valid,
  output logic [AW-1:0] tag,
  output logic [7:0]    data,
  output logic          hit
);

  // slot storage; invalidation outranks a load issued in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (inval) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      tag   <= load_tag;
      data  <= load_data;
    end
  end

  assign hit = valid & (tag == cmp_tag);

endmodule

// File: rtl/jtkunio_pcm_fetch.sv
// rtl/jtkunio_pcm_fetch.sv - ADPCM byte prefetch buffer in front of the SDRAM ROM port (JTKUNIO_PCM_PREFETCH_EN adds slot B and prefetch)
module jtkunio_pcm_fetch
  import jtkunio_snd_pkg::*;
#(
  parameter int AW = PCM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          pcm_cs,
  input  logic [AW-1:0] pcm_addr,
  output logic [7:0]    pcm_data,
  output logic          pcm_ok,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic          miss
);

  pcm_state_t    state, state_nx;
  logic [AW-1:0] rom_addr_nx;

  logic          a_valid, a_hit, a_load, a_inval;
  logic [AW-1:0] a_tag, a_load_tag;
  logic [7:0]    a_data, a_load_data;

  logic          pend_valid;
  logic [AW-1:0] pend_addr;
  logic          skip, discard;
  logic          busy, acc, keep, start;
  logic          pend_match, miss_now, demand_wr;

  assign busy  = state != ST_IDLE;
  // the first rom_ok after rom_cs rises belongs to the previous access
  assign acc   = busy & ~skip & rom_ok;
  // an accepted result may only be stored if no flush hit this access
  assign keep  = acc & ~flush & ~discard;
  assign start = ~busy & (state_nx != ST_IDLE);

  // a flush in the same cycle wipes the pending demand before the lookup
  assign pend_match = pend_valid & ~flush & (pend_addr == pcm_addr);
  assign demand_wr  = keep & pend_valid & (rom_addr == pend_addr) & ~miss_now;

  assign a_inval = flush | miss_now;

  jtkunio_pcm_slot #(.AW(AW)) u_slot_a (
    .clk      (clk),
    .rst      (rst),
    .load     (a_load),
    .inval    (a_inval),
    .load_tag (a_load_tag),
    .load_data(a_load_data),
    .cmp_tag  (pcm_addr),
    .valid    (a_valid),
    .tag      (a_tag),
    .data     (a_data),
    .hit      (a_hit)
  );

`ifdef JTKUNIO_PCM_PREFETCH_EN
  logic          b_valid, b_hit, b_load, b_inval;
  logic          promote, pref_match, pref_wr;
  logic [AW-1:0] b_tag, pref_addr;
  logic [7:0]    b_data;

  assign pref_addr  = a_tag + AW'(1);
  assign promote    = pcm_cs & ~flush & ~a_hit & b_hit;
  // the core asking for the byte already being prefetched just waits for it
  assign pref_match = (state == ST_PREF) & ~discard & ~flush & (rom_addr == pcm_addr);
  assign miss_now   = pcm_cs & ~(a_hit & ~flush) & ~promote & ~pend_match & ~pref_match;
  assign pref_wr    = keep & (state == ST_PREF) & a_valid & (rom_addr == pref_addr) & ~miss_now;

  assign a_load      = demand_wr | promote;
  assign a_load_tag  = promote ? b_tag : rom_addr;
  assign a_load_data = promote ? b_data : rom_data;
  assign b_load      = pref_wr;
  assign b_inval     = flush | miss_now | promote;

  jtkunio_pcm_slot #(.AW(AW)) u_slot_b (
    .clk      (clk),
    .rst      (rst),
    .load     (b_load),
    .inval    (b_inval),
    .load_tag (rom_addr),
    .load_data(rom_data),
    .cmp_tag  (pcm_addr),
    .valid    (b_valid),
    .tag      (b_tag),
    .data     (b_data),
    .hit      (b_hit)
  );
`else
  assign miss_now    = pcm_cs & ~(a_hit & ~flush) & ~pend_match;
  assign a_load      = demand_wr;
  assign a_load_tag  = rom_addr;
  assign a_load_data = rom_data;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // next state and the ROM address to hold for the coming access
  always_comb begin
    state_nx    = state;
    rom_addr_nx = rom_addr;
    case (state)
      ST_IDLE: begin
        if (miss_now) begin
          state_nx    = ST_DEMAND;
          rom_addr_nx = pcm_addr;
        end else if (pend_valid & ~flush) begin
          state_nx    = ST_DEMAND;
          rom_addr_nx = pend_addr;
        end
`ifdef JTKUNIO_PCM_PREFETCH_EN
        else if (a_valid & ~b_valid & ~flush & ~promote) begin
          state_nx    = ST_PREF;
          rom_addr_nx = pref_addr;
        end
`endif
      end
      default: begin
        if (acc) state_nx = ST_IDLE;
      end
    endcase
  end

  // access bookkeeping: held address, stale-ok skip, flush discard, pending demand
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr   <= '0;
      skip       <= 1'b0;
      discard    <= 1'b0;
      miss       <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      rom_addr <= rom_addr_nx;
      skip     <= start;
      miss     <= miss_now;
      if (start)             discard <= 1'b0;
      else if (busy & flush) discard <= 1'b1;
      if (flush | demand_wr) pend_valid <= 1'b0;
      if (miss_now) begin
        pend_valid <= 1'b1;
        pend_addr  <= pcm_addr;
      end
    end
  end

  assign rom_cs   = busy;
  assign pcm_ok   = pcm_cs & a_valid & (pcm_addr == a_tag);
  assign pcm_data = a_data;

endmodule

// File: tb/tb_jtkunio_pcm_fetch.sv
// tb/tb_jtkunio_pcm_fetch.sv - directed scoreboard bench for jtkunio_pcm_fetch
module tb_jtkunio_pcm_fetch;

  localparam int AW  = 17;
  localparam int LAT = 4;
`ifdef JTKUNIO_PCM_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, pcm_cs;
  logic [AW-1:0] pcm_addr;
  logic [7:0]    pcm_data;
  logic          pcm_ok, rom_cs;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_ok, miss;

  int vectors = 0;
  int errors  = 0;
  int n_miss  = 0;
  int n_req   = 0;
  int r0;

  logic [AW-1:0] req_log[$];
  logic [7:0]    exp_q[$];

  logic          m_busy;
  int            m_cnt;
  logic [AW-1:0] m_addr = '0;

  always #5 clk = ~clk;

  jtkunio_pcm_fetch #(.AW(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .pcm_cs  (pcm_cs),
    .pcm_addr(pcm_addr),
    .pcm_data(pcm_data),
    .pcm_ok  (pcm_ok),
    .rom_cs  (rom_cs),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .rom_ok  (rom_ok),
    .miss    (miss)
  );

  function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
    return a[7:0] ^ {a[16:13], a[11:8]} ^ 8'hA5;
  endfunction

  function automatic logic [AW-1:0] last_req(input int back);
    if (req_log.size() > back) return req_log[req_log.size() - 1 - back];
    return '1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // SDRAM model: captures a request, answers LAT edges later with a one-cycle rom_ok
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_cnt    <= 0;
      rom_ok   <= 1'b0;
      rom_data <= 8'h00;
    end else begin
      rom_ok <= 1'b0;
      if (!m_busy) begin
        if (rom_cs) begin
          m_busy <= 1'b1;
          m_cnt  <= LAT;
          m_addr <= rom_addr;
          n_req++;
          req_log.push_back(rom_addr);
        end
      end else if (m_cnt > 1) begin
        m_cnt <= m_cnt - 1;
      end else if (m_cnt == 1) begin
        rom_ok   <= 1'b1;
        rom_data <= rom_byte(m_addr);
        m_cnt    <= 0;
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) if (miss) n_miss++;

  always @(negedge clk) if (m_busy && rom_cs) chk("rom_addr_hold", 32'(rom_addr), 32'(m_addr));

  task automatic rd(input logic [AW-1:0] a, input int exp_miss, input int exp_lat,
                    input int flush_at, input string tag);
    int m0;
    int k;
    bit got;
    @(posedge clk); #1;
    pcm_cs   = 1'b1;
    pcm_addr = a;
    exp_q.push_back(rom_byte(a));
    m0  = n_miss;
    got = 1'b0;
    for (k = 0; k < 200; k++) begin
      flush = (k == flush_at);
      @(negedge clk);
      if (pcm_ok) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    chk({tag, "_ok"}, 32'(got), 32'd1);
    if (got) chk({tag, "_data"}, 32'(pcm_data), 32'(exp_q.pop_front()));
    else void'(exp_q.pop_front());
    chk({tag, "_miss"}, n_miss - m0, exp_miss);
    if (exp_lat >= 0) chk({tag, "_lat"}, k, exp_lat);
    @(posedge clk); #1;
    pcm_cs = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    pcm_cs   = 1'b0;
    pcm_addr = '0;
    idle(3);
    @(negedge clk);
    chk("rst_pcm_ok",   32'(pcm_ok),   32'd0);
    chk("rst_pcm_data", 32'(pcm_data), 32'd0);
    chk("rst_rom_cs",   32'(rom_cs),   32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_miss",     32'(miss),     32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    rd(17'h00100, 1, 7, -1, "cold");
    chk("cold_nreq", n_req, 1);
    chk("cold_req_addr", 32'(last_req(0)), 32'h00100);
    @(negedge clk);
    chk("pref_issue_cs",   32'(rom_cs),   PF ? 32'd1 : 32'd0);
    chk("pref_issue_addr", 32'(rom_addr), PF ? 32'h00101 : 32'h00100);
    idle(56);

    for (int a = 'h101; a <= 'h17F; a++) begin
      rd(AW'(a), PF ? 0 : 1, PF ? 1 : 7, -1, "sweep");
      idle(58);
    end
    rd(17'h00180, PF ? 0 : 1, PF ? 1 : 7, -1, "sweep_last");

    r0 = n_req;
    rd(17'h05000, 1, PF ? 12 : 7, -1, "jump");
    chk("jump_nreq", n_req - r0, PF ? 2 : 1);
    chk("jump_prev_req", 32'(last_req(1)), PF ? 32'h00181 : 32'h00180);
    chk("jump_req", 32'(last_req(0)), 32'h05000);
    rd(17'h00181, 1, -1, -1, "jump_discard");
    idle(20);

    rd(17'h1FFFF, 1, 7, -1, "wrap_a");
    idle(20);
    rd(17'h00000, PF ? 0 : 1, PF ? 1 : 7, -1, "wrap");
    chk("wrap_prev_req", 32'(last_req(1)), 32'h1FFFF);
    chk("wrap_req", 32'(last_req(0)), 32'h00000);
    idle(20);

    r0 = n_req;
    rd(17'h02000, 2, 14, 3, "flush");
    chk("flush_nreq", n_req - r0, 2);
    chk("flush_req0", 32'(last_req(1)), 32'h02000);
    chk("flush_req1", 32'(last_req(0)), 32'h02000);
    idle(20);

    rd(17'h03000, 1, 7, -1, "pre_rst");
    idle(20);
    @(posedge clk); #1;
    pcm_cs   = 1'b1;
    pcm_addr = 17'h04000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_cs",   32'(rom_cs), 32'd1);
    chk("rst_busy_miss", 32'(miss),   32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_pcm_ok",   32'(pcm_ok),   32'd0);
    chk("rst_mid_pcm_data", 32'(pcm_data), 32'd0);
    chk("rst_mid_rom_cs",   32'(rom_cs),   32'd0);
    chk("rst_mid_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_mid_miss",     32'(miss),     32'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    pcm_cs = 1'b0;
    idle(5);
    rd(17'h03000, 1, 7, -1, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
